// File: rtl/prefix_reduce_pipe.sv
// rtl/prefix_reduce_pipe.sv - two-stage pipelined AND/OR/XOR prefix reduction with packet accumulation
// S1 registers the beat, S2 computes prefixes and the packet-running result.
module prefix_reduce_pipe #(
   parameter int N_IN  = 4,
   parameter int WIDTH = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  op,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_IN*WIDTH-1:0]       in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [(N_IN-1)*WIDTH-1:0]   out_prefix,
   output logic [WIDTH-1:0]            out_result,
   output logic                        out_last
);

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_XOR = 2'b10;

   typedef enum logic {IDLE, ACCUM} state_t;

   // Encoding 11 falls into the default branch and therefore acts as OR.
   function automatic logic [WIDTH-1:0] apply(input logic [1:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (o)
         OP_AND:  return a & b;
         OP_XOR:  return a ^ b;
         default: return a | b;
      endcase
   endfunction

   state_t state, state_nxt;
   logic [1:0] lat_op, lat_op_nxt, eff_op;

   logic                  s1_valid, s1_first, s1_last;
   logic [1:0]            s1_op;
   logic [N_IN*WIDTH-1:0] s1_data;

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] pre [N_IN-1];
   logic [(N_IN-1)*WIDTH-1:0] pre_flat;
   logic [WIDTH-1:0] red, result;

   logic adv1, adv2, accept;

   assign adv2     = !out_valid | out_ready;
   assign adv1     = !s1_valid | adv2;
   assign in_ready = adv1 & !rst;
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_nxt  = state;
      lat_op_nxt = lat_op;
      eff_op     = (state == IDLE) ? op : lat_op;
      if (accept) begin
         case (state)
            IDLE: if (!in_last) begin
               state_nxt  = ACCUM;
               lat_op_nxt = op;
            end
            ACCUM: if (in_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         lat_op <= 2'b00;
      end else begin
         state  <= state_nxt;
         lat_op <= lat_op_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_op    <= 2'b00;
         s1_data  <= '0;
      end else if (adv1) begin
         s1_valid <= accept;
         if (accept) begin
            s1_first <= (state == IDLE);
            s1_last  <= in_last;
            s1_op    <= eff_op;
            s1_data  <= in_data;
         end
      end
   end

   always_comb begin
      pre[0] = apply(s1_op, s1_data[0 +: WIDTH], s1_data[WIDTH +: WIDTH]);
      for (int j = 1; j < N_IN - 1; j++)
         pre[j] = apply(s1_op, pre[j-1], s1_data[(j+1)*WIDTH +: WIDTH]);
   end

   always_comb begin
      pre_flat = '0;
      for (int j = 0; j < N_IN - 1; j++)
         pre_flat[j*WIDTH +: WIDTH] = pre[j];
   end

   assign red    = pre[N_IN-2];
   assign result = s1_first ? red : apply(s1_op, acc, red);

   // acc only moves together with a beat entering S2, so stalls never double-apply it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_prefix <= '0;
         out_result <= '0;
         out_last   <= 1'b0;
         acc        <= '0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_prefix <= pre_flat;
            out_result <= result;
            out_last   <= s1_last;
            acc        <= result;
         end
      end
   end

endmodule
